// File: rtl/field_draw_sequencer_pkg.sv
// rtl/field_draw_sequencer_pkg.sv - shared state encoding and default sizing for the field draw sequencer
package field_draw_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_LOAD = 2'd2,
        ST_WAIT = 2'd3
    } fds_state_t;

    localparam int unsigned DEF_NUM_FIELDS  = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 65535;

endpackage

// File: rtl/draw_watchdog.sv
// rtl/draw_watchdog.sv - per-field draw completion watchdog; expires on the TIMEOUT_CYC-th enabled cycle
module draw_watchdog
    import field_draw_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int unsigned   CW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q holds the number of enabled cycles already elapsed before the current one
    assign expired_o = enable_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/field_draw_sequencer.sv
// rtl/field_draw_sequencer.sv - walks enabled display fields in order, strobing a load and awaiting draw completion
module field_draw_sequencer
    import field_draw_sequencer_pkg::*;
#(
    parameter int unsigned NUM_FIELDS  = DEF_NUM_FIELDS,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          continuous,
    input  logic                          start,
    input  logic [NUM_FIELDS-1:0]         field_en,
    input  logic                          draw_done,
    output logic [NUM_FIELDS-1:0]         ld,
    output logic [$clog2(NUM_FIELDS)-1:0] field_idx,
    output logic                          busy,
    output logic                          frame_done,
    output logic                          timeout_err
);
    localparam int unsigned           FW      = $clog2(NUM_FIELDS);
    localparam int unsigned           IW      = $clog2(NUM_FIELDS + 1);
    localparam logic [IW-1:0]         IDX_END = IW'(NUM_FIELDS);
    localparam logic [NUM_FIELDS-1:0] ONE     = NUM_FIELDS'(1);

    fds_state_t            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_FIELDS-1:0] pending_q, pending_d;
    logic [NUM_FIELDS-1:0] ld_q, ld_d;
    logic [FW-1:0]         field_idx_q, field_idx_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  err_q, err_d;
    logic                  wd_clear, wd_enable, wd_expired;
    logic [FW-1:0]         idx_fld;
    logic [NUM_FIELDS-1:0] sel;

    // idx runs one past the last field so the scan can spend a cycle recognising frame end
    assign idx_fld = idx_q[FW-1:0];
    assign sel     = ONE << idx_fld;

    draw_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (wd_clear),
        .enable_i  (wd_enable),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pending_d    = pending_q;
        ld_d         = '0;
        field_idx_d  = field_idx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        err_d        = err_q;
        wd_clear     = 1'b0;
        wd_enable    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start || continuous) begin
                    pending_d   = field_en;
                    idx_d       = '0;
                    field_idx_d = '0;
                    busy_d      = 1'b1;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (idx_q == IDX_END) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = ST_IDLE;
                end else if ((pending_q & sel) != '0) begin
                    ld_d        = sel;
                    field_idx_d = idx_fld;
                    state_d     = ST_LOAD;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_LOAD: begin
                wd_clear = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                wd_enable = 1'b1;
                // completion beats a coinciding expiry, so the error flag stays clean
                if (draw_done) begin
                    pending_d = pending_q & ~sel;
                    idx_d     = idx_q + IW'(1);
                    state_d   = ST_SCAN;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    idx_d   = idx_q + IW'(1);
                    state_d = ST_SCAN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            pending_q    <= '0;
            ld_q         <= '0;
            field_idx_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            ld_q         <= ld_d;
            field_idx_q  <= field_idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign ld          = ld_q;
    assign field_idx   = field_idx_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = err_q;

endmodule
